// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI responder: register map, CTRL/STAT bit positions,
// reset values and the byte shifted out when the TX FIFO is empty.
package spi_slave_pkg;

  localparam logic [1:0] ADR_CTRL = 2'd0;
  localparam logic [1:0] ADR_STAT = 2'd1;
  localparam logic [1:0] ADR_DATA = 2'd2;

  localparam int CTRL_IE   = 7;
  localparam int CTRL_EN   = 6;
  localparam int CTRL_CPOL = 3;
  localparam int CTRL_CPHA = 2;

  localparam int STAT_IF      = 7;
  localparam int STAT_OVR     = 6;
  localparam int STAT_TXFULL  = 3;
  localparam int STAT_TXEMPTY = 2;
  localparam int STAT_RXFULL  = 1;
  localparam int STAT_RXEMPTY = 0;

  localparam logic [7:0] CTRL_RESET = 8'h00;
  localparam logic [7:0] STAT_RESET = 8'h05;
  localparam logic [7:0] CTRL_MASK  = 8'hCC;
  localparam logic [7:0] TX_IDLE    = 8'hFF;

endpackage

// File: rtl/spi_slave_fifo.sv
// Synchronous FIFO with flush; pop is honoured before push, so a full FIFO
// accepts a push in the same cycle as a pop.
module spi_slave_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = count[AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_slave_wb_top.sv
// SPI responder with an 8-bit Wishbone register file. SPI pins are synchronised
// into clk_i and edge-detected; RX/TX bytes are buffered in two small FIFOs.
module spi_slave_wb_top
  import spi_slave_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cyc_i,
  input  logic       stb_i,
  input  logic       we_i,
  input  logic [1:0] adr_i,
  input  logic [7:0] dat_i,
  output logic [7:0] dat_o,
  output logic       ack_o,
  output logic       inta_o,
  input  logic       sck_i,
  input  logic       ss_ni,
  input  logic       mosi_i,
  output logic       miso_o,
  output logic       miso_oe_o
);

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
  logic       sck_s, mosi_s, ss_s, sck_q, ss_q;
  logic [7:0] ctrl_q, stat_val, rd_data;
  logic       if_q, ovr_q;
  logic [2:0] bit_cnt;
  logic [7:0] rx_sh, tx_sh, rx_byte, rx_head, tx_head, load_byte;
  logic       byte_done;
  logic       en, ie, cpol, cpha, active, sck_rise, sck_fall;
  logic       sample_edge, shift_edge, ss_fall, ss_rise, load;
  logic       wb_req, wb_wr, wb_rd, tx_push, rx_pop, en_clear, stat_wr;
  logic       rx_full, rx_empty, tx_full, tx_empty, ovr_set;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
      sck_q     <= sck_s;
      ss_q      <= ss_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];

  assign en   = ctrl_q[CTRL_EN];
  assign ie   = ctrl_q[CTRL_IE];
  assign cpol = ctrl_q[CTRL_CPOL];
  assign cpha = ctrl_q[CTRL_CPHA];

  assign active      = en & ~ss_s;
  assign sck_rise    = sck_s & ~sck_q;
  assign sck_fall    = ~sck_s & sck_q;
  assign sample_edge = active & ((cpol == cpha) ? sck_rise : sck_fall);
  // In CPHA=0 the shift edge trailing the 8th sample belongs to a byte already
  // loaded (bit7 on the wire), so it must not advance the shifter.
  assign shift_edge  = active & ((cpol == cpha) ? sck_fall : sck_rise) & (cpha | (bit_cnt != 3'd0));
  assign ss_fall     = en & ss_q & ~ss_s;
  assign ss_rise     = ~ss_q & ss_s;
  assign load        = ss_fall | (sample_edge & (bit_cnt == 3'd7));
  assign load_byte   = tx_empty ? TX_IDLE : tx_head;

  // Wishbone: a request is cyc_i&stb_i while ack_o is low; writes, FIFO pushes
  // and pops land on the following clock, which is the single ack_o cycle that
  // also carries dat_o.
  assign wb_req   = cyc_i & stb_i & ~ack_o;
  assign wb_wr    = wb_req & we_i;
  assign wb_rd    = wb_req & ~we_i;
  assign tx_push  = wb_wr & (adr_i == ADR_DATA);
  assign rx_pop   = wb_rd & (adr_i == ADR_DATA);
  assign stat_wr  = wb_wr & (adr_i == ADR_STAT);
  assign en_clear = wb_wr & (adr_i == ADR_CTRL) & ~dat_i[CTRL_EN] & en;
  assign ovr_set  = byte_done & rx_full & ~rx_pop;

  spi_slave_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk_i), .rst_n(rst_i), .push(byte_done), .pop(rx_pop), .flush(en_clear),
    .wdata(rx_byte), .rdata(rx_head), .full(rx_full), .empty(rx_empty)
  );

  spi_slave_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk_i), .rst_n(rst_i), .push(tx_push), .pop(load), .flush(en_clear),
    .wdata(dat_i), .rdata(tx_head), .full(tx_full), .empty(tx_empty)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rx_byte   <= '0;
      byte_done <= 1'b0;
      miso_o    <= 1'b0;
    end else if (en_clear) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      byte_done <= 1'b0;
      miso_o    <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (ss_rise) begin
        bit_cnt <= '0;
      end else if (sample_edge) begin
        rx_sh   <= {rx_sh[6:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          rx_byte   <= {rx_sh[6:0], mosi_s};
        end
      end
      // CPHA=0 drives bit7 at load; CPHA=1 waits for the first shift edge.
      if (load) begin
        if (cpha) begin
          tx_sh <= load_byte;
        end else begin
          tx_sh  <= {load_byte[6:0], 1'b0};
          miso_o <= load_byte[7];
        end
      end else if (shift_edge) begin
        miso_o <= tx_sh[7];
        tx_sh  <= {tx_sh[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    stat_val               = '0;
    stat_val[STAT_IF]      = if_q;
    stat_val[STAT_OVR]     = ovr_q;
    stat_val[STAT_TXFULL]  = tx_full;
    stat_val[STAT_TXEMPTY] = tx_empty;
    stat_val[STAT_RXFULL]  = rx_full;
    stat_val[STAT_RXEMPTY] = rx_empty;
  end

  always_comb begin
    rd_data = 8'h00;
    case (adr_i)
      ADR_CTRL: rd_data = ctrl_q;
      ADR_STAT: rd_data = stat_val;
      ADR_DATA: rd_data = rx_empty ? 8'h00 : rx_head;
      default:  rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q <= CTRL_RESET;
      if_q   <= 1'b0;
      ovr_q  <= 1'b0;
      ack_o  <= 1'b0;
      dat_o  <= 8'h00;
    end else begin
      ack_o <= wb_req;
      dat_o <= wb_rd ? rd_data : 8'h00;
      if (wb_wr && adr_i == ADR_CTRL) ctrl_q <= dat_i & CTRL_MASK;
      // A set arriving with its W1C clear wins.
      if_q  <= byte_done | (if_q & ~(stat_wr & dat_i[STAT_IF]));
      ovr_q <= ovr_set | (ovr_q & ~(stat_wr & dat_i[STAT_OVR]));
    end
  end

  assign inta_o    = ie & (if_q | ovr_q);
  assign miso_oe_o = en & ~ss_s;

endmodule

// File: tb/tb_spi_slave_wb_top.sv
// Directed bench for spi_slave_wb_top: a Wishbone host and an SPI master drive
// hand-computed vectors and every observation goes through check().
module tb_spi_slave_wb_top;
  import spi_slave_pkg::*;

  logic       clk, rst_n;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_w, dat_r;
  logic       ack, inta;
  logic       sck, ss_n, mosi, miso, miso_oe;
  logic       cpol, cpha;
  logic [7:0] rd, mi;
  int         total, bad;

  spi_slave_wb_top #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .adr_i(adr), .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack), .inta_o(inta),
    .sck_i(sck), .ss_ni(ss_n), .mosi_i(mosi), .miso_o(miso), .miso_oe_o(miso_oe)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%02h exp=0x%02h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic wb_cycle(input logic w, input logic [1:0] a, input logic [7:0] d,
                          output logic [7:0] q);
    logic got;
    got = 1'b0;
    q   = 8'h00;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack) begin
        got = 1'b1;
        q   = dat_r;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("wb_ack_seen", {7'd0, got}, 8'h01);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    wb_cycle(1'b1, a, d, dummy);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [7:0] q);
    wb_cycle(1'b0, a, 8'h00, q);
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    half();
  endtask

  task automatic ss_high();
    half();
    ss_n = 1'b1;
    half();
    half();
  endtask

  task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi_o);
    mi_o = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      if (!cpha) begin
        mosi = mo[i]; half();
        mi_o[i] = miso; sck = ~cpol; half();
        sck = cpol;
      end else begin
        sck = ~cpol; mosi = mo[i]; half();
        mi_o[i] = miso; sck = cpol; half();
      end
    end
  endtask

  task automatic spi_frame(input logic [7:0] mo, output logic [7:0] mi_o);
    ss_low();
    spi_byte(mo, 8, mi_o);
    ss_high();
  endtask

  task automatic set_mode(input int m, input logic ie_bit);
    cpol = m[1];
    cpha = m[0];
    sck  = cpol;
    half();
    wb_write(ADR_CTRL, {ie_bit, 1'b1, 2'b00, cpol, cpha, 2'b00});
  endtask

  // scoreboard of RX bytes expected from the DATA register
  logic [7:0] exp_q[$];

  task automatic drain_rx(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wb_read(ADR_DATA, rd);
      check(tag, rd, e);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; dat_w = 8'h00;
    sck = 1'b0; ss_n = 1'b1; mosi = 1'b0; cpol = 1'b0; cpha = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {7'd0, ack}, 8'h00);
    check("rst_dat_o", dat_r, 8'h00);
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_miso_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_inta", {7'd0, inta}, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(ADR_STAT, rd);  check("rst_stat", rd, STAT_RESET);
    wb_read(ADR_CTRL, rd);  check("rst_ctrl", rd, 8'h00);
    wb_read(2'd3, rd);      check("adr3_read", rd, 8'h00);
    check("ack_single", {7'd0, ack}, 8'h00);

    // mode 0 with interrupt
    set_mode(0, 1'b1);
    wb_write(ADR_DATA, 8'hA5);
    spi_frame(8'h3C, mi);
    check("m0_miso", mi, 8'hA5);
    wb_read(ADR_STAT, rd);  check("m0_stat", rd, 8'h84);
    check("m0_inta", {7'd0, inta}, 8'h01);
    wb_read(ADR_DATA, rd);  check("m0_rx", rd, 8'h3C);
    wb_write(ADR_STAT, 8'h80);
    wb_read(ADR_STAT, rd);  check("m0_stat_clr", rd, 8'h05);
    check("m0_inta_clr", {7'd0, inta}, 8'h00);

    // modes 1..3, loaded TX then empty TX
    for (int m = 1; m < 4; m++) begin
      set_mode(m, 1'b0);
      wb_write(ADR_DATA, 8'h96);
      spi_frame(8'h69, mi);
      check($sformatf("m%0d_miso", m), mi, 8'h96);
      wb_read(ADR_DATA, rd);  check($sformatf("m%0d_rx", m), rd, 8'h69);
      spi_frame(8'h69, mi);
      check($sformatf("m%0d_miso_idle", m), mi, 8'hFF);
      wb_read(ADR_DATA, rd);  check($sformatf("m%0d_rx_idle", m), rd, 8'h69);
    end

    // overflow
    set_mode(0, 1'b0);
    wb_write(ADR_STAT, 8'hC0);
    for (int b = 1; b <= 5; b++) begin
      spi_frame(8'(b), mi);
      if (b <= 4) exp_q.push_back(8'(b));
    end
    wb_read(ADR_STAT, rd);  check("ovr_stat", rd, 8'hC6);
    wb_write(ADR_STAT, 8'h40);
    wb_read(ADR_STAT, rd);  check("ovr_stat_clr", rd, 8'h86);
    // pop lands on the same clock as the 6th byte's RX push
    fork
      spi_frame(8'h06, mi);
      begin
        repeat (8) @(posedge sck);
        repeat (3) @(negedge clk);
        wb_read(ADR_DATA, rd);
      end
    join
    check("ovr_pop_head", rd, exp_q.pop_front());
    exp_q.push_back(8'h06);
    wb_read(ADR_STAT, rd);  check("ovr_none", rd, 8'h86);
    drain_rx("ovr_rx");
    wb_read(ADR_DATA, rd);  check("rx_empty_read", rd, 8'h00);
    wb_write(ADR_STAT, 8'hC0);
    wb_read(ADR_STAT, rd);  check("ovr_final_stat", rd, 8'h05);

    // ss_n rises after 5 bits
    ss_low();
    spi_byte(8'hFF, 5, mi);
    ss_high();
    wb_read(ADR_STAT, rd);  check("abort_stat", rd, 8'h05);
    spi_frame(8'h5A, mi);
    wb_read(ADR_DATA, rd);  check("abort_next_rx", rd, 8'h5A);
    wb_write(ADR_STAT, 8'h80);

    // async reset mid-byte
    wb_write(ADR_DATA, 8'h33);
    ss_low();
    spi_byte(8'hF0, 4, mi);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_mid_miso", {7'd0, miso}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_read(ADR_STAT, rd);  check("rst_mid_stat", rd, 8'h05);
    wb_read(ADR_CTRL, rd);  check("rst_mid_ctrl", rd, 8'h00);
    ss_high();
    set_mode(0, 1'b0);
    wb_write(ADR_DATA, 8'hC3);
    spi_frame(8'h3C, mi);
    check("rst_next_miso", mi, 8'hC3);
    wb_read(ADR_DATA, rd);  check("rst_next_rx", rd, 8'h3C);

    // EN cleared mid-byte: FIFOs flushed, IF kept
    spi_frame(8'h12, mi);
    wb_write(ADR_DATA, 8'h11);
    wb_write(ADR_DATA, 8'h22);
    ss_low();
    spi_byte(8'hAA, 4, mi);
    wb_write(ADR_CTRL, 8'h00);
    check("en_off_oe", {7'd0, miso_oe}, 8'h00);
    wb_read(ADR_STAT, rd);  check("en_off_stat", rd, 8'h85);
    ss_high();
    set_mode(0, 1'b0);
    wb_write(ADR_DATA, 8'h88);
    spi_frame(8'h77, mi);
    check("en_next_miso", mi, 8'h88);
    wb_read(ADR_DATA, rd);  check("en_next_rx", rd, 8'h77);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
